hex_scan_driver: RTL
====================

// Module: hex_scan_driver
// PURPOSE
//  Time-multiplexed scan controller for a multi-digit 7-segment display. Holds a
//  packed hex word, cycles through its digits at a programmable rate, and per
//  digit drives the 4-bit nibble and active-low enable consumed by the
//  downstream hex-to-7-segment decoder. Also drives the active-low digit-select
//  lines.
//  Adds anti-ghosting dead-time, tear-free frame-boundary updates and optional
//  leading-zero blanking.
// PARAMETERS
//  NUM_DIGITS  4      number of digits scanned (>=2)
//  IDX_W       2      digit index width; 2**IDX_W >= NUM_DIGITS
//  DIV_WIDTH   16     slot counter width
//  DIV_MAX     49999  slot length = DIV_MAX+1 clk cycles per digit
//  BLANK_CYC   50     dead-time cycles at start of each slot; 1 <= BLANK_CYC <= DIV_MAX
// PORTS
//  clk      in   1             system clock, rising edge
//  n_rst    in   1             asynchronous reset, active-low
//  load     in   1             capture data_in into staging register this cycle
//  data_in  in   4*NUM_DIGITS  packed hex word; nibble k = data_in[4k+3:4k], k=0 is LS digit
//  blank_lz in   1             1 = blank leading zero digits
//  hex_out  out  4             nibble of the active digit, to decoder data input
//  n_en     out  1             active-low decoder enable (1 = segments off)
//  dig_sel  out  NUM_DIGITS    active-low digit select, one-hot-low when lit
// BEHAVIOUR
//  - State: cnt[DIV_WIDTH] (slot counter), idx[IDX_W] (active digit),
//    shadow (displayed word), staging (loaded word), pending (flag).
//  - Reset (async, n_rst=0): cnt=0, idx=0, shadow=0, staging=0, pending=0.
//    Outputs take reset values immediately, no clock edge: n_en=1,
//    dig_sel=all 1s, hex_out=0.
//  - Outputs are a combinational function of registered state only.
//    There is no combinational path from load/data_in/blank_lz.
//  - Slot timing: cnt counts 0..DIV_MAX, then wraps to 0. When cnt==DIV_MAX,
//    idx advances, wrapping from NUM_DIGITS-1 to 0.
//  - Phase DEAD (cnt < BLANK_CYC): n_en=1, dig_sel=all 1s, hex_out = shadow nibble idx.
//  - Phase SHOW (cnt >= BLANK_CYC): hex_out = shadow nibble idx,
//    dig_sel = all 1s except bit idx = 0, n_en=0. If the digit is blanked,
//    n_en=1 and dig_sel=all 1s for the whole slot.
//  - Blanked digit: blank_lz=1, idx!=0, and nibbles idx..NUM_DIGITS-1 of shadow
//    are all zero. Digit 0 is never blanked. blank_lz is sampled combinationally
//    via the registered state path: a registered copy blank_q is updated every
//    cycle (reset 0).
//  - Load: on load=1, staging<=data_in and pending<=1.
//    Multiple loads within a frame: last one wins.
//  - Commit (frame boundary): on the cycle with cnt==DIV_MAX and idx==NUM_DIGITS-1:
//    - if pending=1: shadow<=staging, pending<=0.
//    - if load=1 in the same cycle: shadow<=data_in, staging<=data_in, pending<=0.
//      The new load takes priority.
//  - The shadow word never changes mid-frame, so there is no tearing.
//  - A frame is NUM_DIGITS*(DIV_MAX+1) cycles. The first frame after reset
//    starts at idx=0, cnt=0.
//  - Reset asserted mid-slot aborts the scan. Pending data is discarded and
//    scanning restarts at idx 0.
// TESTING (NUM_DIGITS=4, IDX_W=2, DIV_WIDTH=4, DIV_MAX=3, BLANK_CYC=1)
//  1. Assert n_rst=0 between clock edges -> n_en=1, dig_sel=4'b1111, hex_out=0
//     immediately. Release -> idx0 slot: cycle0 dead, cycles1-3 n_en=0,
//     dig_sel=1110, hex_out=0.
//  2. load=1 with data_in=16'h1A3F at reset release, wait 16 cycles
//     -> after commit, per slot (4 cycles): digit0 F/1110, digit1 3/1101,
//     digit2 A/1011, digit3 1/0111. First cycle of each slot has n_en=1,
//     dig_sel=1111.
//  3. Tearing: with 16'h1A3F shown, load 16'h1234 during idx=1
//     -> digits 2,3 still show A,1 this frame; next frame shows 4,3,2,1.
//  4. blank_lz=1, word 16'h0050 -> digits 3,2 held n_en=1/dig_sel=1111 for the
//     full slot; digit1=5, digit0=0 lit. Word 16'h0000 -> only digit0 lit,
//     showing 0.
//  5. load=1 exactly on the commit cycle with 16'hBEEF while pending holds
//     16'h1111 -> next frame shows BEEF and pending=0. Two loads in one frame
//     -> only the last is displayed.
//  6. Async n_rst pulse at idx=2, cnt=2 with pending=1 -> outputs reset at once;
//     after release, shadow=0 and idx0 shows 0; staged word not displayed.

Source files
------------

// File: rtl/hex_scan_if.sv
// Display-side bundle for hex_scan_driver: the word to show plus the
// per-digit nibble, decoder enable and digit-select lines.
interface hex_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   data_in;
    logic                      blank_lz;
    logic [3:0]                hex_out;
    logic                      n_en;
    logic [NUM_DIGITS-1:0]     dig_sel;

    modport master (
        output load, data_in, blank_lz,
        input  hex_out, n_en, dig_sel
    );

    modport slave (
        input  load, data_in, blank_lz,
        output hex_out, n_en, dig_sel
    );
endinterface

// File: rtl/hex_scan_driver.sv
// Multiplexed 7-segment scan controller with dead-time between digits,
// frame-boundary word commit and optional leading-zero blanking.
module hex_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int IDX_W      = 2,
    parameter int DIV_WIDTH  = 16,
    parameter int DIV_MAX    = 49999,
    parameter int BLANK_CYC  = 50
) (
    input  logic       clk,
    input  logic       n_rst,
    hex_scan_if.slave  bus
);
    localparam int WORD_W = 4 * NUM_DIGITS;
    localparam logic [DIV_WIDTH-1:0] CNT_LAST  = DIV_WIDTH'(DIV_MAX);
    localparam logic [DIV_WIDTH-1:0] CNT_BLANK = DIV_WIDTH'(BLANK_CYC);
    localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [WORD_W-1:0]    shadow_q, shadow_d;
    logic [WORD_W-1:0]    staging_q, staging_d;
    logic                 pending_q, pending_d;
    logic                 blank_q, blank_d;

    logic slot_end;
    logic frame_end;

    always_comb begin
        cnt_d     = cnt_q + DIV_WIDTH'(1);
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        staging_d = staging_q;
        pending_d = pending_q;
        blank_d   = bus.blank_lz;

        slot_end  = (cnt_q == CNT_LAST);
        frame_end = slot_end && (idx_q == IDX_LAST);

        if (slot_end) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        // A load landing on the commit cycle bypasses staging so it is not lost.
        if (frame_end) begin
            if (bus.load) begin
                shadow_d  = bus.data_in;
                staging_d = bus.data_in;
                pending_d = 1'b0;
            end else if (pending_q) begin
                shadow_d  = staging_q;
                pending_d = 1'b0;
            end
        end else if (bus.load) begin
            staging_d = bus.data_in;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            staging_q <= '0;
            pending_q <= 1'b0;
            blank_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            staging_q <= staging_d;
            pending_q <= pending_d;
            blank_q   <= blank_d;
        end
    end

    // upper_zero[k]: nibbles k..NUM_DIGITS-1 of the displayed word are all zero.
    logic [3:0]            nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] upper_zero;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
        assign nib[gi] = shadow_q[4*gi +: 4];
        if (gi == NUM_DIGITS - 1) begin : g_top
            assign upper_zero[gi] = (nib[gi] == 4'h0);
        end else begin : g_low
            assign upper_zero[gi] = (nib[gi] == 4'h0) && upper_zero[gi+1];
        end
    end

    logic blanked;
    logic lit;

    always_comb begin
        blanked     = blank_q && (idx_q != '0) && upper_zero[idx_q];
        lit         = (cnt_q >= CNT_BLANK) && !blanked;
        bus.hex_out = nib[idx_q];
        bus.n_en    = !lit;
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_sel
        assign bus.dig_sel[gi] = !(lit && (idx_q == IDX_W'(gi)));
    end
endmodule
